timer_controller: RTL and testbench
===================================

// Module: timer_controller
// PURPOSE
// - Memory-mapped timer peripheral on the data bus TIMER slave port; consumes the bus's read/write strobes,
//   word address and write data, and returns read data in the same cycle.
// - Provides a free-running 64-bit cycle counter with atomic high-word snapshot.
// - Provides a reloadable 32-bit down-counter that raises a maskable interrupt (one-shot or periodic).
// - Never stalls; the bus has no stall path for this slave.
// PARAMETERS
// - TIMER_ADDRESS_WIDTH  3  word-address bits decoded (8 word registers)
// - DATA_WIDTH           32 bus data width; fixed at 32, other values unsupported
// PORTS
// - clk        in   1   system clock
// - rst        in   1   reset; asynchronous, active-high
// - read       in   1   read strobe, qualified by address decode upstream
// - write      in   1   write strobe; always full-word (no byte mask)
// - address    in   TIMER_ADDRESS_WIDTH  word offset
// - data_wr    in   32  write data
// - data_rd    out  32  read data, combinational from address, valid in the same cycle
// - interrupt  out  1   level interrupt = STATUS.pending & CTRL.irq_en
// BEHAVIOUR
// - Register map (word offsets):
//   0 COUNT_LO   R: low word, and latches high word into SHADOW_HI; W: loads low word
//   1 COUNT_HI   R: SHADOW_HI; W: loads high word
//   2 RELOAD     R/W
//   3 CURRENT    R/W; down-counter value
//   4 CTRL       [0] enable, [1] periodic, [2] irq_en; other bits read 0
//   5 STATUS     [0] pending; W1C
//   6 reserved   reads 0; writes ignored
//   7 PRESCALE   see CONFIGURATION
// - Reset: COUNT=0, SHADOW_HI=0, RELOAD=0, CURRENT=0, CTRL=0, STATUS=0, prescale state=0, interrupt=0.
//   data_rd with read=0 is 0.
// - COUNT increments by 1 every clk; wraps from 2^64-1 to 0.
//   Carry into the high word on low-word wrap occurs in the same cycle.
// - A bus write to COUNT_LO or COUNT_HI replaces that half.
//   The written value appears next cycle, without that cycle's increment.
//   A carry from the low half is suppressed for the cycle in which the high half is written.
// - SHADOW_HI updates only on a read of offset 0.
//   The value latched is the high word of the same COUNT value returned for the low word.
// - Down-counter: one state register plus tick.
//   Nothing happens when CTRL.enable=0 or tick=0.
//   On a tick with CURRENT!=0: CURRENT <= CURRENT-1.
//   On a tick with CURRENT==0: pending <= 1.
//     periodic=1: CURRENT <= RELOAD.
//     periodic=0: CURRENT stays 0 and CTRL.enable <= 0.
// - Writing RELOAD does not affect CURRENT; software writes CURRENT to arm.
// - Simultaneous events (priority):
//   - Bus write to CURRENT beats the decrement or reload in the same cycle.
//   - Bus write to CTRL beats the hardware clear of enable.
//   - Hardware pending set beats a W1C clear in the same cycle.
// - Period with RELOAD=N, periodic, tick every cycle: pending sets every N+1 cycles.
// - interrupt is combinational from registered state; no extra latency beyond the pending register.
// - Asserting rst mid-operation clears all state immediately; no partial-update hazards.
// - read and write asserted together: the write takes effect.
//   The read returns the pre-write value; the offset-0 latch still occurs.
// CONFIGURATION
// - TIMER_PRESCALER_EN defined:
//   - PRESCALE at offset 7 is R/W, reset 0. An internal 32-bit prescale counter runs alongside it.
//   - tick=1 when prescale counter == PRESCALE, and the counter then resets to 0; otherwise it increments.
//   - A write to PRESCALE also zeroes the prescale counter.
//   - PRESCALE=0 gives a tick every cycle.
//   - COUNT is never prescaled.
// - TIMER_PRESCALER_EN undefined: tick=1 every cycle; offset 7 reads 0, writes ignored; no prescale logic.
// TESTING
// - Reset release, idle 10 cycles, read offset 0 then 1 -> 0x0000000A (+/- bench offset fixed), then 0x00000000;
//   interrupt=0 throughout.
// - Write COUNT_HI=0x1, COUNT_LO=0xFFFFFFFE; read offset 0 two cycles later -> 0x00000000, then offset 1 -> 0x00000002.
// - RELOAD=3, CURRENT=3, CTRL=0x7 -> pending and interrupt rise 4 cycles after CTRL write, then every 4 cycles;
//   W1C on STATUS drops interrupt next cycle.
// - One-shot: CURRENT=2, CTRL=0x5 -> pending after 3 ticks; CTRL reads 0x4; CURRENT holds 0; no further sets.
// - W1C to STATUS in the exact cycle pending sets -> STATUS reads 1; interrupt stays high.
// - With TIMER_PRESCALER_EN: PRESCALE=4, CURRENT=1, CTRL=0x5 -> pending after 10 cycles.
//   Without the macro: offset 7 reads 0 after writing 0x4.

Source files
------------

// File: rtl/timer_controller.sv
// timer_controller: memory-mapped timer peripheral on the TIMER slave port.
//   - free-running 64-bit cycle counter with high-word snapshot on low-word read
//   - reloadable 32-bit down-counter with maskable one-shot/periodic interrupt
//   - never stalls; read data is combinational from the address
// Configuration macro: TIMER_PRESCALER_EN enables the PRESCALE register at offset 7
//   and an internal prescale counter that gates the down-counter tick.
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   read       read strobe (already qualified by upstream decode)
//   write      full-word write strobe
//   address    word offset
//   data_wr    write data
//   data_rd    read data, valid in the same cycle, 0 when read=0
//   interrupt  STATUS.pending & CTRL.irq_en
module timer_controller #(
  parameter int unsigned TIMER_ADDRESS_WIDTH = 3,
  parameter int unsigned DATA_WIDTH          = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           read,
  input  logic                           write,
  input  logic [TIMER_ADDRESS_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0]          data_wr,
  output logic [DATA_WIDTH-1:0]          data_rd,
  output logic                           interrupt
);

  localparam logic [TIMER_ADDRESS_WIDTH-1:0] OFF_COUNT_LO = TIMER_ADDRESS_WIDTH'(0);
  localparam logic [TIMER_ADDRESS_WIDTH-1:0] OFF_COUNT_HI = TIMER_ADDRESS_WIDTH'(1);
  localparam logic [TIMER_ADDRESS_WIDTH-1:0] OFF_RELOAD   = TIMER_ADDRESS_WIDTH'(2);
  localparam logic [TIMER_ADDRESS_WIDTH-1:0] OFF_CURRENT  = TIMER_ADDRESS_WIDTH'(3);
  localparam logic [TIMER_ADDRESS_WIDTH-1:0] OFF_CTRL     = TIMER_ADDRESS_WIDTH'(4);
  localparam logic [TIMER_ADDRESS_WIDTH-1:0] OFF_STATUS   = TIMER_ADDRESS_WIDTH'(5);
`ifdef TIMER_PRESCALER_EN
  localparam logic [TIMER_ADDRESS_WIDTH-1:0] OFF_PRESCALE = TIMER_ADDRESS_WIDTH'(7);
`endif

  logic [DATA_WIDTH-1:0] count_lo_q, count_lo_d;
  logic [DATA_WIDTH-1:0] count_hi_q, count_hi_d;
  logic [DATA_WIDTH-1:0] shadow_hi_q, shadow_hi_d;
  logic [DATA_WIDTH-1:0] reload_q, reload_d;
  logic [DATA_WIDTH-1:0] current_q, current_d;
  logic [2:0]            ctrl_q, ctrl_d;       // [0] enable, [1] periodic, [2] irq_en
  logic                  pending_q, pending_d;
  logic                  tick;
  logic                  lo_carry;
  logic                  pending_set;
`ifdef TIMER_PRESCALER_EN
  logic [DATA_WIDTH-1:0] prescale_q, prescale_d;
  logic [DATA_WIDTH-1:0] ps_cnt_q, ps_cnt_d;
`endif

  // Tick generation: every cycle, or once per PRESCALE+1 cycles when prescaled.
`ifdef TIMER_PRESCALER_EN
  always_comb begin
    prescale_d = prescale_q;
    tick       = (ps_cnt_q == prescale_q);
    ps_cnt_d   = tick ? '0 : ps_cnt_q + DATA_WIDTH'(1);
    if (write && address == OFF_PRESCALE) begin
      prescale_d = data_wr;
      ps_cnt_d   = '0;
    end
  end
`else
  always_comb begin
    tick = 1'b1;
  end
`endif

  // Next-state for the cycle counter, snapshot and down-counter.
  always_comb begin
    lo_carry    = (count_lo_q == '1);
    count_lo_d  = count_lo_q + DATA_WIDTH'(1);
    count_hi_d  = count_hi_q + DATA_WIDTH'(lo_carry);
    shadow_hi_d = shadow_hi_q;
    reload_d    = reload_q;
    current_d   = current_q;
    ctrl_d      = ctrl_q;
    pending_d   = pending_q;
    pending_set = 1'b0;

    if (write && address == OFF_COUNT_LO) count_lo_d = data_wr;
    // Writing the high half also drops any carry from the low half this cycle.
    if (write && address == OFF_COUNT_HI) count_hi_d = data_wr;
    // Snapshot the high word that pairs with the low word being returned.
    if (read && address == OFF_COUNT_LO) shadow_hi_d = count_hi_q;
    if (write && address == OFF_RELOAD) reload_d = data_wr;

    if (ctrl_q[0] && tick) begin
      if (current_q != '0) begin
        current_d = current_q - DATA_WIDTH'(1);
      end else begin
        pending_set = 1'b1;
        if (ctrl_q[1]) current_d = reload_q;
        else           ctrl_d[0] = 1'b0;
      end
    end

    // Bus writes override hardware updates; hardware set overrides W1C.
    if (write && address == OFF_CURRENT) current_d = data_wr;
    if (write && address == OFF_CTRL)    ctrl_d    = data_wr[2:0];
    if (write && address == OFF_STATUS && data_wr[0]) pending_d = 1'b0;
    if (pending_set) pending_d = 1'b1;
  end

  // Read mux; returns pre-write values when read and write coincide.
  always_comb begin
    data_rd = '0;
    if (read) begin
      case (address)
        OFF_COUNT_LO: data_rd = count_lo_q;
        OFF_COUNT_HI: data_rd = shadow_hi_q;
        OFF_RELOAD:   data_rd = reload_q;
        OFF_CURRENT:  data_rd = current_q;
        OFF_CTRL:     data_rd = DATA_WIDTH'(ctrl_q);
        OFF_STATUS:   data_rd = DATA_WIDTH'(pending_q);
`ifdef TIMER_PRESCALER_EN
        OFF_PRESCALE: data_rd = prescale_q;
`endif
        default:      data_rd = '0;
      endcase
    end
  end

  assign interrupt = pending_q & ctrl_q[2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_lo_q  <= '0;
      count_hi_q  <= '0;
      shadow_hi_q <= '0;
      reload_q    <= '0;
      current_q   <= '0;
      ctrl_q      <= '0;
      pending_q   <= 1'b0;
`ifdef TIMER_PRESCALER_EN
      prescale_q  <= '0;
      ps_cnt_q    <= '0;
`endif
    end else begin
      count_lo_q  <= count_lo_d;
      count_hi_q  <= count_hi_d;
      shadow_hi_q <= shadow_hi_d;
      reload_q    <= reload_d;
      current_q   <= current_d;
      ctrl_q      <= ctrl_d;
      pending_q   <= pending_d;
`ifdef TIMER_PRESCALER_EN
      prescale_q  <= prescale_d;
      ps_cnt_q    <= ps_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_timer_controller.sv
// Bench for timer_controller: directed bus transactions push expected read data
// into a queue; a monitor on the falling edge pops and compares on every read.
module tb_timer_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [2:0]  address = 3'd0;
  logic [31:0] data_wr = 32'd0;
  logic [31:0] data_rd;
  logic        interrupt;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_d_q[$];
  logic [1:0]  exp_irq_q[$];   // [1] check irq, [0] expected irq
  string       name_q[$];

  timer_controller #(.TIMER_ADDRESS_WIDTH(3), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .read(read), .write(write), .address(address),
    .data_wr(data_wr), .data_rd(data_rd), .interrupt(interrupt)
  );

  always #5 clk = ~clk;

  // One bus cycle: drive, then advance to just after the next rising edge.
  task automatic cyc(input logic r, input logic w, input logic [2:0] a, input logic [31:0] d);
    read = r; write = w; address = a; data_wr = d;
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    cyc(1'b0, 1'b1, a, d);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 3'd0, 32'd0);
  endtask

  // Read (optionally with a simultaneous write) and queue the expected response.
  task automatic rd(input logic [2:0] a, input logic [31:0] exp_d, input logic chk_irq,
                    input logic exp_irq, input string nm,
                    input logic w = 1'b0, input logic [31:0] d = 32'd0);
    exp_d_q.push_back(exp_d);
    exp_irq_q.push_back({chk_irq, exp_irq});
    name_q.push_back(nm);
    cyc(1'b1, w, a, d);
  endtask

  // Monitor: compares on every read cycle; also data_rd must be 0 when idle.
  always @(negedge clk) begin
    if (read) begin
      if (name_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_read: no expected entry, data_rd=%h", data_rd);
      end else begin
        logic [31:0] ed;
        logic [1:0]  ei;
        string       nm;
        ed = exp_d_q.pop_front();
        ei = exp_irq_q.pop_front();
        nm = name_q.pop_front();
        tests++;
        if (data_rd !== ed) begin
          fails++;
          $display("FAIL %s: data_rd=%h expected %h", nm, data_rd, ed);
        end
        if (ei[1]) begin
          tests++;
          if (interrupt !== ei[0]) begin
            fails++;
            $display("FAIL %s_irq: interrupt=%b expected %b", nm, interrupt, ei[0]);
          end
        end
      end
    end else begin
      tests++;
      if (data_rd !== 32'd0) begin
        fails++;
        $display("FAIL idle_rd_zero: data_rd=%h expected 00000000", data_rd);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk); #1;
    rst = 1'b0;

    // Counter after reset: 10 idle cycles (reading reserved offset, irq low).
    for (int i = 0; i < 10; i++) rd(3'd6, 32'd0, 1'b1, 1'b0, "idle_reserved");
    rd(3'd0, 32'h0000000A, 1'b1, 1'b0, "count_lo_after_reset");
    rd(3'd1, 32'h00000000, 1'b1, 1'b0, "shadow_hi_after_reset");

    // Low-word wrap carries into the high word.
    wr(3'd1, 32'h1);
    wr(3'd0, 32'hFFFFFFFE);
    idle();
    idle();
    rd(3'd0, 32'h00000000, 1'b0, 1'b0, "count_lo_wrapped");
    rd(3'd1, 32'h00000002, 1'b0, 1'b0, "shadow_hi_carry");

    // Periodic mode: RELOAD=3 -> pending every 4 cycles.
    wr(3'd2, 32'd3);
    wr(3'd3, 32'd3);
    wr(3'd4, 32'h7);
    for (int i = 0; i < 4; i++) rd(3'd5, 32'd0, 1'b1, 1'b0, "periodic_not_yet");
    rd(3'd5, 32'd1, 1'b1, 1'b1, "periodic_first_set");
    wr(3'd5, 32'd1);
    rd(3'd5, 32'd0, 1'b1, 1'b0, "w1c_clears");
    rd(3'd5, 32'd0, 1'b1, 1'b0, "periodic_gap");
    rd(3'd5, 32'd1, 1'b1, 1'b1, "periodic_second_set");
    wr(3'd5, 32'd1);
    rd(3'd5, 32'd0, 1'b1, 1'b0, "w1c_before_race");
    wr(3'd5, 32'd1);                 // W1C in the cycle pending sets again
    rd(3'd5, 32'd1, 1'b1, 1'b1, "set_beats_w1c");

    // Stop the timer and clear status.
    wr(3'd4, 32'h0);
    wr(3'd5, 32'h1);
    rd(3'd5, 32'd0, 1'b1, 1'b0, "disabled_clear");

    // Simultaneous read and write returns the pre-write value.
    rd(3'd2, 32'd3, 1'b0, 1'b0, "rd_wr_old_value", 1'b1, 32'h55);
    rd(3'd2, 32'h55, 1'b0, 1'b0, "rd_wr_new_value");

    // Reserved offset ignores writes.
    wr(3'd6, 32'hDEADBEEF);
    rd(3'd6, 32'd0, 1'b0, 1'b0, "reserved_reads_zero");

    // One-shot: CURRENT=2 -> pending after 3 ticks, enable self-clears.
    wr(3'd3, 32'd2);
    wr(3'd4, 32'h5);
    for (int i = 0; i < 3; i++) rd(3'd5, 32'd0, 1'b1, 1'b0, "oneshot_not_yet");
    rd(3'd5, 32'd1, 1'b1, 1'b1, "oneshot_set");
    rd(3'd4, 32'h4, 1'b1, 1'b1, "oneshot_ctrl");
    rd(3'd3, 32'h0, 1'b0, 1'b0, "oneshot_current");
    wr(3'd5, 32'h1);
    for (int i = 0; i < 6; i++) rd(3'd5, 32'd0, 1'b1, 1'b0, "oneshot_no_reset");
    rd(3'd3, 32'h0, 1'b0, 1'b0, "oneshot_current_hold");

`ifdef TIMER_PRESCALER_EN
    // Prescaled one-shot: PRESCALE=4, CURRENT=1 -> pending 10 cycles after PRESCALE write.
    wr(3'd3, 32'd1);
    wr(3'd7, 32'd4);
    wr(3'd4, 32'h5);
    for (int i = 0; i < 9; i++) rd(3'd5, 32'd0, 1'b1, 1'b0, "prescale_not_yet");
    rd(3'd5, 32'd1, 1'b1, 1'b1, "prescale_set");
    rd(3'd7, 32'd4, 1'b0, 1'b0, "prescale_readback");
`else
    wr(3'd7, 32'h4);
    rd(3'd7, 32'd0, 1'b0, 1'b0, "offset7_reads_zero");
`endif

    // Asynchronous reset mid-operation clears everything immediately.
    rst = 1'b1;
    for (int a = 0; a < 6; a++) rd(3'(a), 32'd0, 1'b1, 1'b0, "reset_clears");
    rst = 1'b0;
    idle();
    idle();

    tests++;
    if (name_q.size() != 0) begin
      fails++;
      $display("FAIL queue_drained: %0d entries left expected 0", name_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
